sim_test_monitor: RTL and testbench

//  Parametrised end-of-test monitor for riscv-tests runs on cpu_top; replaces fixed-delay $finish in benches.

---
 rtl/sim_test_monitor.sv | 159 +++++++++++++++
 tb/tb_sim_test_monitor.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sim_test_monitor.sv
// End-of-test monitor: snoops tohost stores for a pass/fail verdict, enforces a cycle timeout
// and counts RUN cycles and retired instructions. Optional stall detection: SIM_TEST_MONITOR_STALL_DETECT_EN.
module sim_test_monitor #(
    parameter int unsigned        ADDR_W       = 32,
    parameter int unsigned        DATA_W       = 32,
    parameter logic [ADDR_W-1:0]  TOHOST_ADDR  = 32'h0000_1000,
    parameter int unsigned        MAX_CYCLES   = 10000,
    parameter int unsigned        RETIRE_LANES = 1,
    parameter int unsigned        CNT_W        = 32,
    parameter int unsigned        STALL_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    clear,
    input  logic                    st_valid,
    input  logic [ADDR_W-1:0]       st_addr,
    input  logic [DATA_W/8-1:0]     st_wstrb,
    input  logic [DATA_W-1:0]       st_wdata,
    input  logic [RETIRE_LANES-1:0] retire_vld,
    output logic                    done,
    output logic                    pass,
    output logic                    fail,
    output logic                    timeout,
    output logic                    stall,
    output logic [DATA_W-2:0]       test_num,
    output logic [CNT_W-1:0]        cycle_cnt,
    output logic [CNT_W-1:0]        retire_cnt
);

    typedef enum logic [2:0] {
        StIdle,
        StRun,
        StPass,
        StFail,
        StTmo
`ifdef SIM_TEST_MONITOR_STALL_DETECT_EN
        , StStall
`endif
    } state_t;

    localparam logic [CNT_W-1:0] CycLimit = CNT_W'(MAX_CYCLES - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cycle_q, cycle_d, cycle_inc;
    logic [CNT_W-1:0]  retire_q, retire_d, retire_sat;
    logic [DATA_W-2:0] test_num_q, test_num_d;
    logic [CNT_W+2:0]  retire_sum;
    logic [2:0]        pop;
    logic              hit, tmo_hit;

    assign hit     = st_valid & (st_addr[ADDR_W-1:2] == TOHOST_ADDR[ADDR_W-1:2]) & st_wstrb[0];
    assign tmo_hit = (cycle_q == CycLimit);

    always_comb begin
        pop = '0;
        for (int i = 0; i < int'(RETIRE_LANES); i++) begin
            pop = pop + 3'(retire_vld[i]);
        end
    end

    // Sum in three extra bits so any overflow is visible before clipping to all-ones.
    assign retire_sum = {3'b000, retire_q} + (CNT_W+3)'(pop);
    assign retire_sat = (|retire_sum[CNT_W+2:CNT_W]) ? '1 : retire_sum[CNT_W-1:0];
    assign cycle_inc  = (&cycle_q) ? cycle_q : cycle_q + 1'b1;

`ifdef SIM_TEST_MONITOR_STALL_DETECT_EN
    localparam int unsigned IdleW = $clog2(STALL_CYCLES + 1);
    logic [IdleW-1:0] idle_q, idle_d, idle_nxt;

    assign idle_nxt = (|retire_vld) ? '0 : idle_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    logic unused_ok;
    assign unused_ok = ^{st_addr, st_wstrb, (STALL_CYCLES != 0)};
`endif

    always_comb begin
        state_d    = state_q;
        cycle_d    = cycle_q;
        retire_d   = retire_q;
        test_num_d = test_num_q;
`ifdef SIM_TEST_MONITOR_STALL_DETECT_EN
        idle_d     = idle_q;
`endif
        if (clear) begin
            state_d    = StIdle;
            cycle_d    = '0;
            retire_d   = '0;
            test_num_d = '0;
`ifdef SIM_TEST_MONITOR_STALL_DETECT_EN
            idle_d     = '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) state_d = StRun;
                end
                StRun: begin
                    cycle_d  = cycle_inc;
                    retire_d = retire_sat;
`ifdef SIM_TEST_MONITOR_STALL_DETECT_EN
                    idle_d   = idle_nxt;
`endif
                    // Verdict hits take priority over the timeout limit in the same cycle.
                    if (hit && st_wdata == DATA_W'(1)) begin
                        state_d = StPass;
                    end else if (hit && st_wdata[0]) begin
                        state_d    = StFail;
                        test_num_d = st_wdata[DATA_W-1:1];
                    end else if (tmo_hit) begin
                        state_d = StTmo;
                    end
`ifdef SIM_TEST_MONITOR_STALL_DETECT_EN
                    else if (idle_nxt == IdleW'(STALL_CYCLES)) begin
                        state_d = StStall;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cycle_q    <= '0;
            retire_q   <= '0;
            test_num_q <= '0;
        end else begin
            state_q    <= state_d;
            cycle_q    <= cycle_d;
            retire_q   <= retire_d;
            test_num_q <= test_num_d;
        end
    end

    assign pass       = (state_q == StPass);
    assign fail       = (state_q == StFail);
    assign timeout    = (state_q == StTmo);
`ifdef SIM_TEST_MONITOR_STALL_DETECT_EN
    assign stall      = (state_q == StStall);
`else
    assign stall      = 1'b0;
`endif
    assign done       = pass | fail | timeout | stall;
    assign test_num   = test_num_q;
    assign cycle_cnt  = cycle_q;
    assign retire_cnt = retire_q;

endmodule

// File: tb/tb_sim_test_monitor.sv
// Bench for sim_test_monitor: table of store vectors checked through a scoreboard queue,
// plus hand sequences for timeout, retire counting, clear/start priority and async reset.
module tb_sim_test_monitor;

    localparam int unsigned MAXC = 100;

    logic        clk = 1'b0;
    logic        rst_n, start, clear, st_valid;
    logic [31:0] st_addr, st_wdata;
    logic [3:0]  st_wstrb;
    logic [1:0]  retire_vld;
    logic        done, pass, fail, timeout, stall;
    logic [30:0] test_num;
    logic [31:0] cycle_cnt, retire_cnt;

    sim_test_monitor #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .TOHOST_ADDR (32'h0000_1000),
        .MAX_CYCLES  (MAXC),
        .RETIRE_LANES(2),
        .CNT_W       (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .clear     (clear),
        .st_valid  (st_valid),
        .st_addr   (st_addr),
        .st_wstrb  (st_wstrb),
        .st_wdata  (st_wdata),
        .retire_vld(retire_vld),
        .done      (done),
        .pass      (pass),
        .fail      (fail),
        .timeout   (timeout),
        .stall     (stall),
        .test_num  (test_num),
        .cycle_cnt (cycle_cnt),
        .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned idle;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [1:0]  ret;
    } vec_t;

    typedef struct {
        logic        done, pass, fail, tmo;
        logic [30:0] tn;
        logic [31:0] cyc, ret;
    } exp_t;

    vec_t vecs[8];
    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Independent reference: one RUN pass of idle quiet cycles then a single store cycle.
    function automatic exp_t model(input vec_t v);
        exp_t e;
        logic is_hit;
        e.cyc  = v.idle + 1;
        e.ret  = (int'(v.ret[0]) + int'(v.ret[1])) * (v.idle + 1);
        is_hit = (v.addr[31:2] == 30'h400) && v.wstrb[0];
        e.pass = is_hit && (v.wdata == 32'd1);
        e.fail = is_hit && v.wdata[0] && (v.wdata != 32'd1);
        e.tn   = e.fail ? v.wdata[31:1] : 31'd0;
        e.tmo  = !e.pass && !e.fail && (e.cyc == MAXC);
        e.done = e.pass | e.fail | e.tmo;
        return e;
    endfunction

    task automatic do_clear();
        @(negedge clk) clear = 1'b1;
        @(negedge clk) clear = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic check_out(input int idx);
        exp_t e;
        if (sb.size() == 0) begin
            chk($sformatf("v%0d_sb_empty", idx), 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        chk($sformatf("v%0d_done", idx), done, e.done);
        chk($sformatf("v%0d_pass", idx), pass, e.pass);
        chk($sformatf("v%0d_fail", idx), fail, e.fail);
        chk($sformatf("v%0d_timeout", idx), timeout, e.tmo);
        chk($sformatf("v%0d_test_num", idx), test_num, e.tn);
        chk($sformatf("v%0d_cycle_cnt", idx), cycle_cnt, e.cyc);
        chk($sformatf("v%0d_retire_cnt", idx), retire_cnt, e.ret);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        do_clear();
        pulse_start();
        retire_vld = v.ret;
        repeat (v.idle) @(negedge clk);
        st_valid = 1'b1;
        st_addr  = v.addr;
        st_wstrb = v.wstrb;
        st_wdata = v.wdata;
        sb.push_back(model(v));
        @(negedge clk);
        st_valid   = 1'b0;
        retire_vld = 2'b00;
        check_out(idx);
    endtask

    task automatic drive_store(input logic [31:0] a, input logic [31:0] d);
        st_valid = 1'b1; st_addr = a; st_wstrb = 4'hf; st_wdata = d;
        @(negedge clk);
        st_valid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{idle: 50, addr: 32'h1000, wstrb: 4'hf, wdata: 32'h1,         ret: 2'b01};
        vecs[1] = '{idle: 3,  addr: 32'h1000, wstrb: 4'hf, wdata: 32'h7,         ret: 2'b11};
        vecs[2] = '{idle: 0,  addr: 32'h1000, wstrb: 4'hf, wdata: 32'h0,         ret: 2'b10};
        vecs[3] = '{idle: 2,  addr: 32'h1004, wstrb: 4'hf, wdata: 32'h1,         ret: 2'b00};
        vecs[4] = '{idle: 2,  addr: 32'h1000, wstrb: 4'h2, wdata: 32'h1,         ret: 2'b01};
        vecs[5] = '{idle: 99, addr: 32'h1000, wstrb: 4'hf, wdata: 32'h1,         ret: 2'b00};
        vecs[6] = '{idle: 5,  addr: 32'h1003, wstrb: 4'h1, wdata: 32'hFFFF_FFFF, ret: 2'b11};
        vecs[7] = '{idle: 99, addr: 32'h1000, wstrb: 4'hf, wdata: 32'h25,        ret: 2'b10};

        rst_n = 1'b0; start = 1'b0; clear = 1'b0; st_valid = 1'b0;
        st_addr = '0; st_wstrb = '0; st_wdata = '0; retire_vld = '0;
        #12;
        chk("rst_done", done, 1'b0);
        chk("rst_pass", pass, 1'b0);
        chk("rst_stall", stall, 1'b0);
        chk("rst_cycle_cnt", cycle_cnt, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // Stores in IDLE are ignored and counters hold at zero.
        @(negedge clk);
        drive_store(32'h1000, 32'h1);
        chk("idle_store_done", done, 1'b0);
        chk("idle_cycle_cnt", cycle_cnt, 32'd0);

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Timeout after exactly MAXC RUN cycles, then everything freezes.
        do_clear();
        pulse_start();
        repeat (MAXC - 1) @(negedge clk);
        chk("tmo_early_timeout", timeout, 1'b0);
        chk("tmo_early_cycle_cnt", cycle_cnt, MAXC - 1);
        @(negedge clk);
        chk("tmo_timeout", timeout, 1'b1);
        chk("tmo_done", done, 1'b1);
        chk("tmo_pass", pass, 1'b0);
        chk("tmo_cycle_cnt", cycle_cnt, MAXC);
        drive_store(32'h1000, 32'h1);
        chk("tmo_late_hit_pass", pass, 1'b0);
        chk("tmo_frozen_cycle_cnt", cycle_cnt, MAXC);

        // start outside IDLE is ignored.
        pulse_start();
        chk("start_in_tmo_timeout", timeout, 1'b1);
        chk("start_in_tmo_cycle_cnt", cycle_cnt, MAXC);

        // clear beats start in the same cycle.
        @(negedge clk) begin clear = 1'b1; start = 1'b1; end
        @(negedge clk) begin clear = 1'b0; start = 1'b0; end
        chk("clr_start_done", done, 1'b0);
        chk("clr_start_cycle_cnt", cycle_cnt, 32'd0);
        @(negedge clk);
        chk("clr_start_still_idle", cycle_cnt, 32'd0);

        // Two-lane retire counting.
        pulse_start();
        retire_vld = 2'b11;
        repeat (10) @(negedge clk);
        retire_vld = 2'b01;
        repeat (5) @(negedge clk);
        retire_vld = 2'b00;
        chk("retire_cnt", retire_cnt, 32'd25);
        chk("retire_cycle_cnt", cycle_cnt, 32'd15);
        chk("retire_done", done, 1'b0);

        // Asynchronous reset mid-RUN, away from any clock edge.
        #2 rst_n = 1'b0;
        #1;
        chk("async_cycle_cnt", cycle_cnt, 32'd0);
        chk("async_retire_cnt", retire_cnt, 32'd0);
        chk("async_done", done, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        chk("async_stays_idle", cycle_cnt, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
